mem_port_responder: RTL and testbench

- Responder end of the CPU memory request interface: services the instruction, read_data and write_data ports driven by the core/cache side.
- Each port uses an active-low request paired with an active-low ready/written pulse.
- Arbitrates the three ports onto a single Avalon-MM master toward the SDRAM controller, one transaction at a time.
- Sits inside the system wrapper between the CPU-facing conduits and the SDRAM controller slave.

---
 rtl/mem_port_responder_if.sv | 54 +++++
 rtl/mem_port_responder.sv | 148 ++++++++++++++
 tb/tb_mem_port_responder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_responder_if.sv
// Bundle of the three CPU-side request ports plus the Avalon-MM master
// toward the SDRAM controller. The slave modport is the responder's view;
// the master modport is the view of whatever drives the requests and
// plays the Avalon slave.
interface mem_port_responder_if #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32
);
    logic                  instruction_read_n;
    logic [ADDR_WIDTH-1:0] instruction_read_address;
    logic [DATA_WIDTH-1:0] instruction_read_data;
    logic                  instruction_data_ready_n;

    logic                  read_data_read_n;
    logic [ADDR_WIDTH-1:0] read_data_read_address;
    logic [DATA_WIDTH-1:0] read_data_read_data;
    logic                  read_data_data_ready_n;

    logic                  write_data_write_n;
    logic [ADDR_WIDTH-1:0] write_data_write_address;
    logic [DATA_WIDTH-1:0] write_data_write_data;
    logic                  write_data_data_written_n;

    logic [ADDR_WIDTH-1:0] avm_address;
    logic                  avm_read;
    logic                  avm_write;
    logic [DATA_WIDTH-1:0] avm_writedata;
    logic [3:0]            avm_byteenable;
    logic                  avm_waitrequest;
    logic [DATA_WIDTH-1:0] avm_readdata;
    logic                  avm_readdatavalid;

    modport slave (
        input  instruction_read_n, instruction_read_address,
        output instruction_read_data, instruction_data_ready_n,
        input  read_data_read_n, read_data_read_address,
        output read_data_read_data, read_data_data_ready_n,
        input  write_data_write_n, write_data_write_address, write_data_write_data,
        output write_data_data_written_n,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport master (
        output instruction_read_n, instruction_read_address,
        input  instruction_read_data, instruction_data_ready_n,
        output read_data_read_n, read_data_read_address,
        input  read_data_read_data, read_data_data_ready_n,
        output write_data_write_n, write_data_write_address, write_data_write_data,
        input  write_data_data_written_n,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/mem_port_responder.sv
// Responder for the CPU instruction / read_data / write_data ports.
// Arbitrates the three active-low requests onto one Avalon-MM master,
// one transaction at a time: IDLE -> ISSUE -> (WAIT_DATA) -> RESPOND.
// Optional build macro MEM_PORT_ROUND_ROBIN_EN switches IDLE arbitration
// from fixed priority (write > read_data > instruction) to round-robin.
module mem_port_responder #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESPOND} state_t;
    typedef enum logic [1:0] {PORT_WRITE = 2'd0, PORT_READ = 2'd1, PORT_INSTR = 2'd2} port_t;

    state_t                state, state_next;
    port_t                 sel, grant;
    logic [2:0]            req;
    logic                  grant_valid;
    logic [ADDR_WIDTH-1:0] addr_pick;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] idata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Index of the lowest set request bit; bit 0 is the highest priority.
    function automatic logic [1:0] first_set(input logic [2:0] r);
        if (r[0]) return 2'd0;
        if (r[1]) return 2'd1;
        return 2'd2;
    endfunction

    // Request vector indexed by port id.
    assign req = {~bus.instruction_read_n, ~bus.read_data_read_n, ~bus.write_data_write_n};
    assign grant_valid = |req;

`ifdef MEM_PORT_ROUND_ROBIN_EN
    port_t      rr_ptr;
    logic [2:0] req_rot;
    logic [2:0] grant_sum;

    // Rotate requests so the pointer's port sits at bit 0, pick, rotate back.
    always_comb begin
        case (rr_ptr)
            PORT_READ:  req_rot = {req[0], req[2:1]};
            PORT_INSTR: req_rot = {req[1:0], req[2]};
            default:    req_rot = req;
        endcase
        grant_sum = {1'b0, first_set(req_rot)} + {1'b0, rr_ptr};
        if (grant_sum >= 3'd3) grant_sum = grant_sum - 3'd3;
        grant = port_t'(grant_sum[1:0]);
    end

    // Pointer moves to the port after the one granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= PORT_WRITE;
        end else if (state == IDLE && grant_valid) begin
            case (grant)
                PORT_WRITE: rr_ptr <= PORT_READ;
                PORT_READ:  rr_ptr <= PORT_INSTR;
                default:    rr_ptr <= PORT_WRITE;
            endcase
        end
    end
`else
    // Fixed priority: write > read_data > instruction.
    always_comb grant = port_t'(first_set(req));
`endif

    // Address of the port being granted this cycle.
    always_comb begin
        case (grant)
            PORT_WRITE: addr_pick = bus.write_data_write_address;
            PORT_READ:  addr_pick = bus.read_data_read_address;
            default:    addr_pick = bus.instruction_read_address;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Transaction latch on grant and read-data capture in WAIT_DATA.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel     <= PORT_WRITE;
            addr_q  <= '0;
            wdata_q <= '0;
            idata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                sel    <= grant;
                addr_q <= addr_pick & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
                if (grant == PORT_WRITE) wdata_q <= bus.write_data_write_data;
            end
            if (state == WAIT_DATA && bus.avm_readdatavalid) begin
                if (sel == PORT_INSTR) idata_q <= bus.avm_readdata;
                else                   rdata_q <= bus.avm_readdata;
            end
        end
    end

    // Next-state logic and Avalon / completion outputs.
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next                    = state;
        bus.avm_read                  = 1'b0;
        bus.avm_write                 = 1'b0;
        bus.instruction_data_ready_n  = 1'b1;
        bus.read_data_data_ready_n    = 1'b1;
        bus.write_data_data_written_n = 1'b1;
        unique case (state)
            IDLE: begin
                if (grant_valid) state_next = ISSUE;
            end
            ISSUE: begin
                bus.avm_read  = (sel != PORT_WRITE);
                bus.avm_write = (sel == PORT_WRITE);
                if (!bus.avm_waitrequest)
                    state_next = (sel == PORT_WRITE) ? RESPOND : WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.avm_readdatavalid) state_next = RESPOND;
            end
            RESPOND: begin
                bus.instruction_data_ready_n  = (sel != PORT_INSTR);
                bus.read_data_data_ready_n    = (sel != PORT_READ);
                bus.write_data_data_written_n = (sel != PORT_WRITE);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.avm_address           = addr_q;
    assign bus.avm_writedata         = wdata_q;
    assign bus.avm_byteenable        = 4'hF;
    assign bus.instruction_read_data = idata_q;
    assign bus.read_data_read_data   = rdata_q;
endmodule

// File: tb/tb_mem_port_responder.sv
// Self-checking bench for mem_port_responder: directed port stimulus, an
// Avalon slave with configurable stall and read latency, and a per-cycle
// transaction-level scoreboard of grants, addresses and completion pulses.
module tb_mem_port_responder;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_port_responder_if #(.ADDR_WIDTH(25), .DATA_WIDTH(32)) bus ();

    mem_port_responder #(.ADDR_WIDTH(25), .DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- Avalon slave model ----------------
    logic [31:0] mem [logic [24:0]];
    int          stall_cfg = 0;
    int          rd_lat    = 1;
    int          inject_req = 0;
    logic [31:0] inject_data = '0;

    function automatic logic [31:0] mem_read(input logic [24:0] a);
        if (mem.exists(a)) return mem[a];
        return {7'h0, a} ^ 32'h5A5A_0000;
    endfunction

    initial begin
        int          stall_left;
        int          rd_cnt;
        int          inject_done;
        bit          in_cmd;
        logic [24:0] rd_addr;
        stall_left = 0; rd_cnt = 0; inject_done = 0; in_cmd = 0; rd_addr = '0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(posedge clock);
            #2;
            bus.avm_readdatavalid = 1'b0;
            if (reset) begin
                rd_cnt = 0;
                in_cmd = 0;
                bus.avm_waitrequest = 1'b0;
            end else begin
                if (inject_req != inject_done) begin
                    inject_done = inject_req;
                    bus.avm_readdatavalid = 1'b1;
                    bus.avm_readdata      = inject_data;
                end
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        bus.avm_readdatavalid = 1'b1;
                        bus.avm_readdata      = mem_read(rd_addr);
                    end
                end
                if (bus.avm_read || bus.avm_write) begin
                    if (!in_cmd) begin
                        in_cmd = 1;
                        stall_left = stall_cfg;
                    end
                    if (stall_left > 0) begin
                        bus.avm_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        bus.avm_waitrequest = 1'b0;
                        in_cmd = 0;
                        if (bus.avm_read) begin
                            rd_cnt  = rd_lat;
                            rd_addr = bus.avm_address;
                        end else begin
                            mem[bus.avm_address] = bus.avm_writedata;
                        end
                    end
                end else begin
                    bus.avm_waitrequest = 1'b0;
                end
            end
        end
    end

    // ---------------- Scoreboard model ----------------
    // Port ids: 0 write, 1 read_data, 2 instruction.
    function automatic int model_pick(input logic [2:0] r, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (r[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [24:0] port_addr(input int p);
        case (p)
            0:       return bus.write_data_write_address;
            1:       return bus.read_data_read_address;
            default: return bus.instruction_read_address;
        endcase
    endfunction

    int          cyc = 0;
    logic [2:0]  req_prev = '0;
    logic        cmd_prev = 1'b0;
    logic        rst_prev = 1'b1;
    bit          outst = 0;
    bit          accepted = 0;
    bit          got_valid = 0;
    int          cur_port = 0;
    int          acc_cyc = 0;
    int          exp_pulse = -1;
    int          rr_ptr_m = 0;
    logic [24:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] exp_pdata = '0;
    logic [31:0] exp_idata = '0;
    logic [31:0] exp_rdata = '0;

    always @(negedge clock) begin
        logic [2:0] req_now, pulse, exp_vec;
        logic       cmd;
        int         g;
        cyc++;
        req_now = {~bus.instruction_read_n, ~bus.read_data_read_n, ~bus.write_data_write_n};
        pulse   = {~bus.instruction_data_ready_n, ~bus.read_data_data_ready_n,
                   ~bus.write_data_data_written_n};
        cmd     = bus.avm_read | bus.avm_write;
        check("byteenable", {28'h0, bus.avm_byteenable}, 32'hF);
        check("rd_wr_exclusive", {31'h0, bus.avm_read & bus.avm_write}, 32'h0);
        if (rst_prev) begin
            check("rst_pulses", {29'h0, pulse}, 32'h0);
            check("rst_avm_cmd", {31'h0, cmd}, 32'h0);
            check("rst_avm_address", {7'h0, bus.avm_address}, 32'h0);
            check("rst_avm_writedata", bus.avm_writedata, 32'h0);
            check("rst_instr_data", bus.instruction_read_data, 32'h0);
            check("rst_read_data", bus.read_data_read_data, 32'h0);
            outst = 0; exp_pulse = -1; rr_ptr_m = 0;
            exp_idata = '0; exp_rdata = '0;
        end else begin
            if (cmd && !cmd_prev) begin
`ifdef MEM_PORT_ROUND_ROBIN_EN
                g = model_pick(req_prev, rr_ptr_m);
`else
                g = model_pick(req_prev, 0);
`endif
                check("cmd_has_request", {31'h0, g >= 0}, 32'h1);
                if (g < 0) g = 0;
                check("cmd_single_outstanding", {31'h0, outst}, 32'h0);
                check("cmd_kind", {31'h0, bus.avm_write}, {31'h0, g == 0});
                cmd_addr = port_addr(g) & ~25'h3;
                check("cmd_address", {7'h0, bus.avm_address}, {7'h0, cmd_addr});
                cmd_wdata = bus.write_data_write_data;
                if (g == 0) check("cmd_writedata", bus.avm_writedata, cmd_wdata);
                outst = 1; accepted = 0; got_valid = 0; cur_port = g; exp_pulse = -1;
                rr_ptr_m = (g + 1) % 3;
            end else if (cmd && outst && !accepted) begin
                check("cmd_hold_address", {7'h0, bus.avm_address}, {7'h0, cmd_addr});
                check("cmd_hold_kind", {31'h0, bus.avm_write}, {31'h0, cur_port == 0});
                if (cur_port == 0) check("cmd_hold_writedata", bus.avm_writedata, cmd_wdata);
            end else if (cmd && accepted) begin
                check("cmd_after_accept", {31'h0, cmd}, 32'h0);
            end
            if (cmd && outst && !accepted && !bus.avm_waitrequest) begin
                accepted = 1;
                acc_cyc  = cyc;
                if (cur_port == 0) exp_pulse = cyc + 1;
            end
            if (outst && accepted && !got_valid && cur_port != 0 &&
                bus.avm_readdatavalid && cyc > acc_cyc) begin
                got_valid = 1;
                exp_pulse = cyc + 1;
                exp_pdata = mem_read(cmd_addr);
            end
            if (pulse != 3'b000 || (outst && exp_pulse == cyc)) begin
                exp_vec = (outst && exp_pulse == cyc) ? 3'(1 << cur_port) : 3'b000;
                check("completion_pulse", {29'h0, pulse}, {29'h0, exp_vec});
                if (exp_vec != 3'b000) begin
                    if (cur_port == 2) exp_idata = exp_pdata;
                    if (cur_port == 1) exp_rdata = exp_pdata;
                    outst = 0;
                    exp_pulse = -1;
                end
            end
            check("instr_data_value", bus.instruction_read_data, exp_idata);
            check("read_data_value", bus.read_data_read_data, exp_rdata);
        end
        req_prev = req_now;
        cmd_prev = cmd;
        rst_prev = reset;
    end

    // ---------------- Directed stimulus ----------------
    task automatic release_port(input int p);
        case (p)
            0:       bus.write_data_write_n = 1'b1;
            1:       bus.read_data_read_n   = 1'b1;
            default: bus.instruction_read_n = 1'b1;
        endcase
    endtask

    function automatic int pulsed_port();
        if (!bus.write_data_data_written_n) return 0;
        if (!bus.read_data_data_ready_n)    return 1;
        if (!bus.instruction_data_ready_n)  return 2;
        return -1;
    endfunction

    task automatic apply_reset();
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
    endtask

    // Collect up to n completion pulses; release each port in the cycle
    // after its pulse unless hold is set, then release everything.
    task automatic collect(input int n, input bit hold, output int order[$]);
        int rel;
        rel = -1;
        order = {};
        for (int c = 0; c < 100 && order.size() < n; c++) begin
            tick();
            if (rel >= 0 && !hold) release_port(rel);
            rel = -1;
            @(negedge clock);
            if (pulsed_port() >= 0) begin
                order.push_back(pulsed_port());
                rel = pulsed_port();
            end
        end
        tick();
        for (int p = 0; p < 3; p++) release_port(p);
        check("collect_count", order.size(), n);
    endtask

    initial begin
        int          order[$];
        bit          held;
        bit          quiet;
        int          npulse, nrise, p1, r2;
        bit          prev_rd, released;
        int          after;

        reset = 1'b1;
        bus.instruction_read_n = 1'b1; bus.instruction_read_address = '0;
        bus.read_data_read_n   = 1'b1; bus.read_data_read_address   = '0;
        bus.write_data_write_n = 1'b1; bus.write_data_write_address = '0;
        bus.write_data_write_data = '0;
        mem[25'h100] = 32'hDEAD_BEEF;
        mem[25'h304] = 32'h0BAD_F00D;
        mem[25'h408] = 32'h1357_9BDF;
        mem[25'h500] = 32'h1111_2222;

        repeat (3) tick();
        @(negedge clock);
        check("reset_ready_n", {29'h0, bus.instruction_data_ready_n, bus.read_data_data_ready_n,
                                bus.write_data_data_written_n}, 32'h7);
        check("reset_avm_read", {31'h0, bus.avm_read}, 32'h0);
        check("reset_avm_address", {7'h0, bus.avm_address}, 32'h0);
        tick(); reset = 1'b0;

        // Single fetch, readdatavalid 3 cycles after accept.
        rd_lat = 3;
        tick(); bus.instruction_read_address = 25'h0000103; bus.instruction_read_n = 1'b0;
        tick(); @(negedge clock);
        check("fetch_avm_read_t1", {31'h0, bus.avm_read}, 32'h1);
        check("fetch_avm_address", {7'h0, bus.avm_address}, 32'h0000100);
        tick(); @(negedge clock);
        check("fetch_avm_read_t2", {31'h0, bus.avm_read}, 32'h0);
        repeat (3) tick();
        @(negedge clock);
        check("fetch_ready_t5", {31'h0, bus.instruction_data_ready_n}, 32'h0);
        check("fetch_data_t5", bus.instruction_read_data, 32'hDEAD_BEEF);
        tick(); bus.instruction_read_n = 1'b1;
        @(negedge clock);
        check("fetch_ready_t6", {31'h0, bus.instruction_data_ready_n}, 32'h1);
        check("fetch_data_hold", bus.instruction_read_data, 32'hDEAD_BEEF);

        // Write with four waitrequest cycles.
        stall_cfg = 4;
        tick();
        bus.write_data_write_address = 25'h40;
        bus.write_data_write_data    = 32'h1234_5678;
        bus.write_data_write_n       = 1'b0;
        held = 1;
        for (int k = 0; k < 5; k++) begin
            tick(); @(negedge clock);
            held &= (bus.avm_write == 1'b1) && (bus.avm_address == 25'h40) &&
                    (bus.avm_writedata == 32'h1234_5678) && bus.write_data_data_written_n;
        end
        check("write_stall_hold_5", {31'h0, held}, 32'h1);
        tick(); @(negedge clock);
        check("write_written_t6", {31'h0, bus.write_data_data_written_n}, 32'h0);
        check("write_avm_write_t6", {31'h0, bus.avm_write}, 32'h0);
        tick(); bus.write_data_write_n = 1'b1;
        @(negedge clock);
        check("write_written_t7", {31'h0, bus.write_data_data_written_n}, 32'h1);
        stall_cfg = 0;

        // Simultaneous requests from all three ports.
        apply_reset();
        rd_lat = 1;
        tick();
        bus.write_data_write_address = 25'h200; bus.write_data_write_data = 32'hCAFE_F00D;
        bus.read_data_read_address   = 25'h304;
        bus.instruction_read_address = 25'h408;
        bus.write_data_write_n = 1'b0; bus.read_data_read_n = 1'b0; bus.instruction_read_n = 1'b0;
        collect(3, 0, order);
        if (order.size() == 3) begin
            check("simul_grant0", order[0], 0);
            check("simul_grant1", order[1], 1);
            check("simul_grant2", order[2], 2);
        end
        check("simul_read_data", bus.read_data_read_data, 32'h0BAD_F00D);
        check("simul_instr_data", bus.instruction_read_data, 32'h1357_9BDF);
        check("simul_mem_written", mem_read(25'h200), 32'hCAFE_F00D);

        // Back-to-back fetches with the request held across the pulse.
        tick(); bus.instruction_read_address = 25'h500; bus.instruction_read_n = 1'b0;
        npulse = 0; nrise = 0; p1 = -1; r2 = -100; prev_rd = 0; released = 0; after = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (npulse == 2 && !released) begin
                bus.instruction_read_n = 1'b1;
                released = 1;
            end
            @(negedge clock);
            if (bus.avm_read && !prev_rd) begin
                nrise++;
                if (nrise == 2) r2 = c;
            end
            prev_rd = bus.avm_read;
            if (!bus.instruction_data_ready_n) begin
                npulse++;
                if (npulse == 1) p1 = c;
            end
            if (released) after++;
            if (after >= 5) break;
        end
        bus.instruction_read_n = 1'b1;
        check("b2b_pulses", npulse, 2);
        check("b2b_reads", nrise, 2);
        check("b2b_gap_ok", {31'h0, (r2 - p1 >= 1) && (r2 - p1 <= 2)}, 32'h1);
        check("b2b_data", bus.instruction_read_data, 32'h1111_2222);

        // Reset while waiting for read data, then late readdatavalid.
        rd_lat = 20;
        tick(); bus.instruction_read_address = 25'h600; bus.instruction_read_n = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; bus.instruction_read_n = 1'b1;
        tick(); reset = 1'b0;
        tick(); inject_data = 32'hAAAA_5555; inject_req++;
        quiet = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            quiet &= bus.instruction_data_ready_n && bus.read_data_data_ready_n &&
                     bus.write_data_data_written_n && !bus.avm_read &&
                     (bus.instruction_read_data == 32'h0) && (bus.avm_address == 25'h0);
            tick();
        end
        check("rst_mid_read_quiet", {31'h0, quiet}, 32'h1);

        // Stray readdatavalid while idle.
        inject_data = 32'h1; inject_req++;
        quiet = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            quiet &= bus.instruction_data_ready_n && bus.read_data_data_ready_n &&
                     bus.write_data_data_written_n && (bus.read_data_read_data == 32'h0);
            tick();
        end
        check("stray_valid_ignored", {31'h0, quiet}, 32'h1);

`ifdef MEM_PORT_ROUND_ROBIN_EN
        // All three held low continuously: grants rotate.
        apply_reset();
        rd_lat = 1;
        tick();
        bus.write_data_write_n = 1'b0; bus.read_data_read_n = 1'b0; bus.instruction_read_n = 1'b0;
        collect(4, 1, order);
        if (order.size() == 4) begin
            check("rr_grant0", order[0], 0);
            check("rr_grant1", order[1], 1);
            check("rr_grant2", order[2], 2);
            check("rr_grant3", order[3], 0);
        end
`endif

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
